// File: rtl/coincid_pkg.sv
// Shared definitions for the coincidence trigger path: sequencer state codes,
// default timing constants and counter slot indices.
package coincid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FIRE      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_BUSY      = 3'd3,
        ST_DEAD      = 3'd4
    } trg_state_e;

    localparam int unsigned TRG_PULSE_CYCLES     = 5;
    localparam logic [15:0] BUSY_TIMEOUT         = 16'd500;
    localparam logic [23:0] SI_DEAD_TIME_SET_NUM = 24'd15000;

    localparam int NUM_CNT     = 3;
    localparam int CNT_TRG     = 0;
    localparam int CNT_LOST    = 1;
    localparam int CNT_TIMEOUT = 2;

    // A programmed dead time of zero falls back to the build-time default.
    function automatic logic [23:0] eff_dead_time(input logic [23:0] dead_time,
                                                  input logic [23:0] dflt);
        return (dead_time == 24'd0) ? dflt : dead_time;
    endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at 0xFFFF; clear dominates increment.
module sat_cnt16 (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/trg_busy_sequencer.sv
// Walks each accepted coincidence trigger through pulse, tracker busy
// handshake and dead time, and keeps accepted/lost/timeout statistics.
module trg_busy_sequencer #(
    parameter int unsigned TRG_PULSE_CYCLES     = coincid_pkg::TRG_PULSE_CYCLES,
    parameter logic [15:0] BUSY_TIMEOUT         = coincid_pkg::BUSY_TIMEOUT,
    parameter logic [23:0] SI_DEAD_TIME_SET_NUM = coincid_pkg::SI_DEAD_TIME_SET_NUM
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        coincid_trg_in,
    input  logic [4:0]  coincid_tag_in,
    input  logic [1:0]  busy_syn_in,
    input  logic        trg_enable_in,
    input  logic [23:0] dead_time_in,
    input  logic        cnt_clr_in,
    output logic        trg_out,
    output logic [4:0]  trg_tag_out,
    output logic        trg_busy_out,
    output logic [15:0] trg_cnt_out,
    output logic [15:0] trg_lost_cnt_out,
    output logic [15:0] busy_timeout_cnt_out,
    output logic [2:0]  state_out
);
    import coincid_pkg::*;

    localparam logic [23:0] PULSE_LOAD   = 24'(TRG_PULSE_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LOAD = {8'd0, BUSY_TIMEOUT - 16'd1};

    trg_state_e state;
    logic [23:0] tmr;
    logic [23:0] dead_load;
    logic        busy_any;
    logic        accept;
    logic        trg_lost;
    logic        timeout_hit;

    logic [NUM_CNT-1:0]       cnt_inc;
    logic [NUM_CNT-1:0][15:0] cnt_val;

    assign busy_any    = |busy_syn_in;
    assign accept      = (state == ST_IDLE) && coincid_trg_in && trg_enable_in && !busy_any;
    // Outside IDLE every trigger is lost, enabled or not.
    assign trg_lost    = coincid_trg_in &&
                         ((state != ST_IDLE) || (trg_enable_in && busy_any));
    assign timeout_hit = (state == ST_WAIT_BUSY) && !busy_any && (tmr == 24'd0);
    assign dead_load   = eff_dead_time(dead_time_in, SI_DEAD_TIME_SET_NUM) - 24'd1;

    // One down-counter serves pulse width, busy timeout and dead time in turn;
    // each phase ends in the cycle the counter reads zero.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= ST_IDLE;
            tmr          <= '0;
            trg_out      <= 1'b0;
            trg_tag_out  <= '0;
            trg_busy_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state        <= ST_FIRE;
                        tmr          <= PULSE_LOAD;
                        trg_out      <= 1'b1;
                        trg_tag_out  <= coincid_tag_in;
                        trg_busy_out <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    if (tmr == 24'd0) begin
                        state   <= ST_WAIT_BUSY;
                        tmr     <= TIMEOUT_LOAD;
                        trg_out <= 1'b0;
                    end else begin
                        tmr <= tmr - 24'd1;
                    end
                end
                ST_WAIT_BUSY: begin
                    // A busy arriving on the final timeout cycle still counts as a response.
                    if (busy_any) begin
                        state <= ST_BUSY;
                    end else if (tmr == 24'd0) begin
                        state <= ST_DEAD;
                        tmr   <= dead_load;
                    end else begin
                        tmr <= tmr - 24'd1;
                    end
                end
                ST_BUSY: begin
                    if (!busy_any) begin
                        state <= ST_DEAD;
                        tmr   <= dead_load;
                    end
                end
                ST_DEAD: begin
                    if (tmr == 24'd0) begin
                        state        <= ST_IDLE;
                        trg_busy_out <= 1'b0;
                    end else begin
                        tmr <= tmr - 24'd1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    tmr          <= '0;
                    trg_out      <= 1'b0;
                    trg_busy_out <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_inc              = '0;
        cnt_inc[CNT_TRG]     = accept;
        cnt_inc[CNT_LOST]    = trg_lost;
        cnt_inc[CNT_TIMEOUT] = timeout_hit;
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        sat_cnt16 u_cnt (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .clr    (cnt_clr_in),
            .inc    (cnt_inc[i]),
            .cnt    (cnt_val[i])
        );
    end

    assign trg_cnt_out          = cnt_val[CNT_TRG];
    assign trg_lost_cnt_out     = cnt_val[CNT_LOST];
    assign busy_timeout_cnt_out = cnt_val[CNT_TIMEOUT];
    assign state_out            = state;

endmodule

// File: tb/tb_trg_busy_sequencer.sv
// Self-checking bench for trg_busy_sequencer: table of full trigger sequences
// with a tag/latency scoreboard, plus hand-written corner-case sequences.
module tb_trg_busy_sequencer;

    localparam int P = 5;

    logic        clk_in         = 1'b0;
    logic        rst_in         = 1'b1;
    logic        coincid_trg_in = 1'b0;
    logic [4:0]  coincid_tag_in = '0;
    logic [1:0]  busy_syn_in    = '0;
    logic        trg_enable_in  = 1'b0;
    logic [23:0] dead_time_in   = '0;
    logic        cnt_clr_in     = 1'b0;
    logic        trg_out;
    logic [4:0]  trg_tag_out;
    logic        trg_busy_out;
    logic [15:0] trg_cnt_out;
    logic [15:0] trg_lost_cnt_out;
    logic [15:0] busy_timeout_cnt_out;
    logic [2:0]  state_out;

    int checks = 0;
    int errors = 0;

    trg_busy_sequencer dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .coincid_trg_in       (coincid_trg_in),
        .coincid_tag_in       (coincid_tag_in),
        .busy_syn_in          (busy_syn_in),
        .trg_enable_in        (trg_enable_in),
        .dead_time_in         (dead_time_in),
        .cnt_clr_in           (cnt_clr_in),
        .trg_out              (trg_out),
        .trg_tag_out          (trg_tag_out),
        .trg_busy_out         (trg_busy_out),
        .trg_cnt_out          (trg_cnt_out),
        .trg_lost_cnt_out     (trg_lost_cnt_out),
        .busy_timeout_cnt_out (busy_timeout_cnt_out),
        .state_out            (state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  tag;
        logic [23:0] dead;
        logic [1:0]  busy_val;
        int          busy_at;    // tick at which busy is first sampled high (0 = never)
        int          busy_len;
        int          exp_idle;   // tick (trigger tick = 1) at which IDLE is back
        int          exp_to;
        logic [14:0] exp_seq;    // visited states, 3 bits each, oldest first
    } vec_t;

    typedef struct {
        logic [4:0]  tag;
        int          idle;
        int          to;
        logic [14:0] seq;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (state_out != 3'd0 && n < limit) begin
            tick();
            n++;
        end
        chk(name, state_out, 32'd0);
    endtask

    task automatic run_seq(input vec_t v);
        int          pulses = 0;
        int          busy_hi = 0;
        int          idle_at = -1;
        int          first_pulse = -1;
        bit          popped = 1'b0;
        logic [14:0] seq = '0;
        logic [2:0]  last = 3'd0;
        logic [15:0] cnt0 = trg_cnt_out;
        logic [15:0] to0 = busy_timeout_cnt_out;
        exp_t        e;
        sb.push_back('{v.tag, v.exp_idle, v.exp_to, v.exp_seq});
        coincid_tag_in = v.tag;
        dead_time_in   = v.dead;
        coincid_trg_in = 1'b1;
        for (int k = 1; k <= v.exp_idle + 50; k++) begin
            busy_syn_in = (v.busy_at != 0 && k >= v.busy_at && k < v.busy_at + v.busy_len)
                          ? v.busy_val : 2'b00;
            tick();
            coincid_trg_in = 1'b0;
            if (trg_out && !popped) begin
                e = sb.pop_front();
                popped = 1'b1;
                first_pulse = k;
                chk("seq_tag", trg_tag_out, e.tag);
            end
            if (trg_out) pulses++;
            if (trg_busy_out) busy_hi++;
            if (state_out != last) begin
                seq  = {seq[11:0], state_out};
                last = state_out;
            end
            if (state_out == 3'd0) begin
                idle_at = k;
                break;
            end
        end
        busy_syn_in = 2'b00;
        if (!popped) begin
            chk("seq_pulse_seen", 32'd0, 32'd1);
            e = sb.pop_front();
        end
        chk("seq_first_pulse", first_pulse, 1);
        chk("seq_pulse_width", pulses, P);
        chk("seq_busy_cycles", busy_hi, e.idle - 1);
        chk("seq_idle_tick", idle_at, e.idle);
        chk("seq_states", seq, e.seq);
        chk("seq_trg_cnt", trg_cnt_out, cnt0 + 16'd1);
        chk("seq_timeouts", busy_timeout_cnt_out - to0, e.to);
        chk("seq_tag_hold", trg_tag_out, e.tag);
    endtask

    initial begin
        logic [15:0] lost0, cnt0, cnt1;
        bit          f_fire, f_busy, f_dead;
        int          k;

        vecs[0] = '{5'h0A, 24'd20, 2'b01, 9, 100, 129, 0, 15'o12340};
        vecs[1] = '{5'h1F, 24'd0,  2'b00, 0, 0, 15506, 1, 15'o01240};
        vecs[2] = '{5'h03, 24'd3,  2'b10, 7, 1,    11, 0, 15'o12340};
        vecs[3] = '{5'h15, 24'd1,  2'b00, 0, 0,   507, 1, 15'o01240};

        trg_enable_in = 1'b1;
        repeat (2) tick();
        chk("rst_trg_out", trg_out, 0);
        chk("rst_tag", trg_tag_out, 0);
        chk("rst_busy_out", trg_busy_out, 0);
        chk("rst_trg_cnt", trg_cnt_out, 0);
        chk("rst_lost_cnt", trg_lost_cnt_out, 0);
        chk("rst_timeout_cnt", busy_timeout_cnt_out, 0);
        chk("rst_state", state_out, 0);
        rst_in = 1'b0;
        tick();

        foreach (vecs[i]) run_seq(vecs[i]);

        // Lost triggers: IDLE with busy, then during FIRE, BUSY and DEAD.
        lost0 = trg_lost_cnt_out;
        cnt0  = trg_cnt_out;
        busy_syn_in    = 2'b01;
        coincid_tag_in = 5'h09;
        coincid_trg_in = 1'b1;
        tick();
        coincid_trg_in = 1'b0;
        busy_syn_in    = 2'b00;
        chk("busy_reject_state", state_out, 0);
        chk("busy_reject_lost", trg_lost_cnt_out, lost0 + 16'd1);
        chk("busy_reject_cnt", trg_cnt_out, cnt0);
        dead_time_in   = 24'd10;
        coincid_tag_in = 5'h07;
        coincid_trg_in = 1'b1;
        tick();
        cnt1 = trg_cnt_out;
        f_fire = 0; f_busy = 0; f_dead = 0;
        k = 1;
        while (state_out != 3'd0 && k < 200) begin
            coincid_trg_in = 1'b0;
            if (state_out == 3'd1 && !f_fire) begin coincid_trg_in = 1'b1; f_fire = 1; end
            else if (state_out == 3'd3 && !f_busy) begin coincid_trg_in = 1'b1; f_busy = 1; end
            else if (state_out == 3'd4 && !f_dead) begin coincid_trg_in = 1'b1; f_dead = 1; end
            k++;
            busy_syn_in = (k >= 7 && k < 27) ? 2'b01 : 2'b00;
            tick();
        end
        coincid_trg_in = 1'b0;
        busy_syn_in    = 2'b00;
        chk("lost_idle_tick", k, 37);
        chk("lost_count", trg_lost_cnt_out, lost0 + 16'd4);
        chk("lost_trg_cnt", trg_cnt_out, cnt1);
        chk("lost_accept_cnt", cnt1, cnt0 + 16'd1);

        // Enable dropped mid-sequence: sequence completes, next trigger ignored.
        dead_time_in   = 24'd5;
        coincid_tag_in = 5'h11;
        coincid_trg_in = 1'b1;
        tick();
        coincid_trg_in = 1'b0;
        k = 1;
        while (state_out != 3'd0 && k < 100) begin
            k++;
            busy_syn_in = (k >= 7 && k < 17) ? 2'b10 : 2'b00;
            tick();
            if (state_out == 3'd3) trg_enable_in = 1'b0;
        end
        busy_syn_in = 2'b00;
        chk("en_drop_idle_tick", k, 22);
        cnt0  = trg_cnt_out;
        lost0 = trg_lost_cnt_out;
        coincid_tag_in = 5'h1E;
        coincid_trg_in = 1'b1;
        tick();
        coincid_trg_in = 1'b0;
        chk("en_low_state", state_out, 0);
        chk("en_low_trg_out", trg_out, 0);
        chk("en_low_trg_cnt", trg_cnt_out, cnt0);
        chk("en_low_lost", trg_lost_cnt_out, lost0);
        chk("en_low_tag", trg_tag_out, 5'h11);
        trg_enable_in = 1'b1;

        // Asynchronous reset during the third FIRE cycle.
        dead_time_in   = 24'd5;
        coincid_tag_in = 5'h0C;
        coincid_trg_in = 1'b1;
        tick();
        coincid_trg_in = 1'b0;
        tick();
        tick();
        chk("fire3_trg_out", trg_out, 1);
        #2 rst_in = 1'b1;
        #1;
        chk("async_rst_trg_out", trg_out, 0);
        chk("async_rst_tag", trg_tag_out, 0);
        chk("async_rst_busy_out", trg_busy_out, 0);
        chk("async_rst_trg_cnt", trg_cnt_out, 0);
        chk("async_rst_lost", trg_lost_cnt_out, 0);
        chk("async_rst_timeouts", busy_timeout_cnt_out, 0);
        chk("async_rst_state", state_out, 0);
        tick();
        rst_in = 1'b0;
        coincid_tag_in = 5'h13;
        coincid_trg_in = 1'b1;
        tick();
        coincid_trg_in = 1'b0;
        chk("post_rst_state", state_out, 1);
        chk("post_rst_trg_out", trg_out, 1);
        chk("post_rst_tag", trg_tag_out, 5'h13);
        chk("post_rst_trg_cnt", trg_cnt_out, 1);
        wait_idle("post_rst_idle", 600);

        // Lost counter saturation: trigger held high through a long sequence.
        dead_time_in   = 24'd65600;
        coincid_tag_in = 5'h1C;
        coincid_trg_in = 1'b1;
        tick();
        chk("sat_accept_state", state_out, 1);
        repeat (65540) tick();
        coincid_trg_in = 1'b0;
        chk("sat_lost_cnt", trg_lost_cnt_out, 16'hFFFF);
        chk("sat_state_dead", state_out, 4);
        wait_idle("sat_idle", 1000);

        // Clear coincident with an accept leaves every counter at zero.
        dead_time_in   = 24'd1;
        coincid_tag_in = 5'h02;
        cnt_clr_in     = 1'b1;
        coincid_trg_in = 1'b1;
        tick();
        cnt_clr_in     = 1'b0;
        coincid_trg_in = 1'b0;
        chk("clr_trg_cnt", trg_cnt_out, 0);
        chk("clr_lost_cnt", trg_lost_cnt_out, 0);
        chk("clr_timeouts", busy_timeout_cnt_out, 0);
        chk("clr_state", state_out, 1);
        chk("clr_tag", trg_tag_out, 5'h02);
        wait_idle("clr_idle", 600);
        chk("clr_final_timeouts", busy_timeout_cnt_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
